// File: rtl/traffic_timer_if.sv
// traffic_timer_if
//   Start/expire handshake between the traffic light controller and its
//   interval timer, plus the threshold config port.
//
//   Signals:
//     ST       controller -> timer  restart request (level, sampled per edge)
//     hold     controller -> timer  freeze count (and prescaler)
//     cfg_we   controller -> timer  pending-threshold write strobe
//     cfg_sel  controller -> timer  0 = short threshold, 1 = long threshold
//     cfg_data controller -> timer  threshold value
//     TS       timer -> controller  short interval expired
//     TL       timer -> controller  long interval expired
//     cnt      timer -> controller  current count (observe only)
//
//   Modports: master = controller side, slave = timer side.
interface traffic_timer_if #(
    parameter int CNT_W = 8
);
    logic             ST;
    logic             hold;
    logic             cfg_we;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             TS;
    logic             TL;
    logic [CNT_W-1:0] cnt;

    modport master (
        output ST, hold, cfg_we, cfg_sel, cfg_data,
        input  TS, TL, cnt
    );

    modport slave (
        input  ST, hold, cfg_we, cfg_sel, cfg_data,
        output TS, TL, cnt
    );
endinterface

// File: rtl/traffic_timer.sv
// traffic_timer
//   Interval timer for the highway/farm-road traffic light controller.
//   ST restarts the count; TS/TL report that the short/long threshold has
//   been reached and stay high until the next ST. Thresholds are written to
//   pending registers and only become active on a restart, so a write never
//   disturbs an interval already being timed.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     tif      traffic_timer_if.slave (ST, hold, cfg_we, cfg_sel, cfg_data,
//              TS, TL, cnt)
//
//   Build option:
//     TIMER_PRESCALE_EN  when defined, the count advances once every
//                        PRESCALE clocks instead of every clock.
module traffic_timer #(
    parameter int CNT_W    = 8,
    parameter int TS_CNT   = 4,
    parameter int TL_CNT   = 12,
    parameter int PRESCALE = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    traffic_timer_if.slave  tif
);

    localparam logic [CNT_W-1:0] TS_RST = CNT_W'(TS_CNT);
    localparam logic [CNT_W-1:0] TL_RST = CNT_W'(TL_CNT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ts_act;
    logic [CNT_W-1:0] tl_act;
    logic [CNT_W-1:0] ts_pend;
    logic [CNT_W-1:0] tl_pend;
    logic             step_en;

    // Saturating increment: the count parks at all-ones instead of wrapping,
    // so an expired flag can never drop back by itself.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef TIMER_PRESCALE_EN
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;

    // The count steps on the same edge that the prescaler wraps.
    assign step_en = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (tif.ST) begin
            pre <= '0;
        end else if (!tif.hold) begin
            pre <= step_en ? '0 : pre + 1'b1;
        end
    end
`else
    // PRESCALE has no effect without the prescaler.
    logic unused_prescale;
    assign unused_prescale = (PRESCALE >= 1);
    assign step_en         = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            ts_act  <= TS_RST;
            tl_act  <= TL_RST;
            ts_pend <= TS_RST;
            tl_pend <= TL_RST;
        end else begin
            if (tif.cfg_we) begin
                if (tif.cfg_sel) tl_pend <= tif.cfg_data;
                else             ts_pend <= tif.cfg_data;
            end

            if (tif.ST) begin
                cnt <= '0;
                // A write on the restart edge goes straight to the active
                // threshold so it applies to the interval starting now.
                ts_act <= (tif.cfg_we && !tif.cfg_sel) ? tif.cfg_data : ts_pend;
                tl_act <= (tif.cfg_we &&  tif.cfg_sel) ? tif.cfg_data : tl_pend;
            end else if (!tif.hold && step_en) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    assign tif.TS  = (cnt >= ts_act);
    assign tif.TL  = (cnt >= tl_act);
    assign tif.cnt = cnt;

endmodule

// File: tb/tb_traffic_timer.sv
`timescale 1ns/1ps
module tb_traffic_timer;

    localparam int W = 8;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = 10;
`else
    localparam int PS = 1;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    traffic_timer_if #(.CNT_W(W)) tif();

    traffic_timer #(
        .CNT_W   (W),
        .TS_CNT  (4),
        .TL_CNT  (12),
        .PRESCALE(10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .tif    (tif)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         ts;
        logic         tl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int m_cnt, m_pre, m_tsa, m_tla, m_tsp, m_tlp;

    int ts_at, tl_at, n;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0;
        m_tsa = 4; m_tsp = 4;
        m_tla = 12; m_tlp = 12;
    endtask

    // One clock: drive inputs on the falling edge, predict, compare after the
    // rising edge.
    task automatic cyc(input bit st, input bit h, input bit we = 1'b0,
                       input bit sel = 1'b0, input int d = 0);
        exp_t e;
        @(negedge clk);
        tif.ST       = st;
        tif.hold     = h;
        tif.cfg_we   = we;
        tif.cfg_sel  = sel;
        tif.cfg_data = W'(d);
        if (we) begin
            if (sel) m_tlp = d;
            else     m_tsp = d;
        end
        if (st) begin
            m_cnt = 0; m_pre = 0;
            m_tsa = m_tsp; m_tla = m_tlp;
        end else if (!h) begin
            if (m_pre == PS - 1) begin
                m_pre = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_pre++;
            end
        end
        e.cnt = W'(m_cnt);
        e.ts  = (m_cnt >= m_tsa);
        e.tl  = (m_cnt >= m_tla);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cnt", tif.cnt, e.cnt);
        chk("TS",  tif.TS,  e.ts);
        chk("TL",  tif.TL,  e.tl);
    endtask

    // Idle clocks until both flags have risen; reports the clock index of each rise.
    task automatic measure(input int maxc, output int t_s, output int t_l);
        t_s = -1; t_l = -1;
        for (int i = 1; i <= maxc; i++) begin
            cyc(1'b0, 1'b0);
            if (tif.TS && t_s < 0) t_s = i;
            if (tif.TL && t_l < 0) t_l = i;
            if (t_s >= 0 && t_l >= 0) break;
        end
    endtask

    // Idle clocks until TS rises; returns the clock count, -1 on timeout.
    task automatic wait_ts(input int maxc, output int cnt_out);
        cnt_out = -1;
        for (int i = 1; i <= maxc; i++) begin
            cyc(1'b0, 1'b0);
            if (tif.TS) begin
                cnt_out = i;
                break;
            end
        end
    endtask

    initial begin
        tif.ST = 1'b0; tif.hold = 1'b1; tif.cfg_we = 1'b0;
        tif.cfg_sel = 1'b0; tif.cfg_data = '0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", tif.cnt, 0);
        chk("rst_TS",  tif.TS,  0);
        chk("rst_TL",  tif.TL,  0);
        @(negedge clk);
        reset_n = 1'b1;

        // Scenario 1: default latencies and saturation
        cyc(1'b1, 1'b0);
        measure(20 * PS, ts_at, tl_at);
        chk("s1_ts_lat", ts_at, 4 * PS);
        chk("s1_tl_lat", tl_at, 12 * PS);
        repeat ((255 - 12) * PS) cyc(1'b0, 1'b0);
        chk("s1_cnt255", tif.cnt, 255);
        repeat (3 * PS) cyc(1'b0, 1'b0);
        chk("s1_no_wrap", tif.cnt, 255);

        // Scenario 2: restart mid-count
        cyc(1'b1, 1'b0);
        repeat (7 * PS) cyc(1'b0, 1'b0);
        chk("s2_ts_at7", tif.TS, 1);
        chk("s2_tl_at7", tif.TL, 0);
        cyc(1'b1, 1'b0);
        chk("s2_cnt0",    tif.cnt, 0);
        chk("s2_ts_fall", tif.TS,  0);
        measure(20 * PS, ts_at, tl_at);
        chk("s2_ts_lat", ts_at, 4 * PS);

        // Scenario 3: hold extends latency; ST wins over hold
        cyc(1'b1, 1'b0);
        repeat (2 * PS) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        chk("s3_hold_cnt", tif.cnt, 2);
        wait_ts(20 * PS, n);
        chk("s3_ts_lat", (n < 0) ? -1 : n + 2 * PS + 3, 4 * PS + 3);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("s3_st_in_hold", tif.cnt, 0);

        // Scenario 4: pending writes, and write bypass on the ST edge
        cyc(1'b1, 1'b0);
        repeat (PS) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_ts(20 * PS, n);
        chk("s4_cnt_at_ts", tif.cnt, 4);
        cyc(1'b1, 1'b0);
        wait_ts(20 * PS, n);
        chk("s4_new_ts_lat", n, 2 * PS);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
        chk("s4_tl_bypass", tif.TL, 1);

        // Scenario 5: asynchronous reset mid-count discards pending writes
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 6);
        repeat (9 * PS - 1) cyc(1'b0, 1'b0);
        chk("s5_cnt9", tif.cnt, 9);
        @(negedge clk);
        tif.hold = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("s5_async_cnt", tif.cnt, 0);
        chk("s5_async_TS",  tif.TS,  0);
        model_reset();
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        measure(20 * PS, ts_at, tl_at);
        chk("s5_ts_lat", ts_at, 4 * PS);
        chk("s5_tl_lat", tl_at, 12 * PS);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
